ifetch_ctrl: RTL and testbench

//   Fetch sequencer for the 32-word instruction ROM (combinational read, word-indexed by PC[31:2]).

---
 rtl/riscv_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 43 ++++
 rtl/ifetch_ctrl.sv | 54 +++++
 tb/tb_ifetch_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core widths, constants and the fetch packet type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_pkt_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: sync prefetch FIFO of fetch packets with async reset and flush
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  fetch_pkt_t din,
  output logic       full,
  output logic       empty,
  output fetch_pkt_t head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  fetch_pkt_t mem [DEPTH];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rd_ptr];
  // storage and pointers; flush drops all entries, pointers wrap on power-of-two depth
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) mem[wr_ptr] <= din;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: fetch sequencer feeding {pc, instr} pairs from the ROM to decode
module ifetch_ctrl
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              MEM_WORDS  = 32,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_pc,
  input  logic [ILEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            fetch_fault
);
  logic [XLEN-1:0] fetch_pc;
  logic fault_c, push, pop, full, empty;
  fetch_pkt_t head, hold;
  assign imem_pc   = fetch_pc;
  assign fault_c   = fetch_pc[1:0] != 2'b00 || fetch_pc >= XLEN'(MEM_WORDS * 4);
  assign out_valid = !empty;
  assign pop       = !redirect_valid && !empty && out_ready;
  assign push      = !redirect_valid && !fetch_fault && !fault_c && (!full || pop);
  assign out_pc    = empty ? hold.pc : head.pc;
  assign out_instr = empty ? hold.instr : head.instr;
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ('{pc: fetch_pc, instr: imem_instr}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );
  // fetch PC advance/redirect, sticky fault, and last-presented head held while empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      fetch_fault <= 1'b0;
      hold        <= '0;
    end else begin
      fetch_pc    <= redirect_valid ? redirect_pc : push ? fetch_pc + 32'd4 : fetch_pc;
      fetch_fault <= !redirect_valid && (fetch_fault || fault_c);
      if (!empty) hold <= head;
    end
  end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed stimulus with a queue-based fetch model checked every cycle
module tb_ifetch_ctrl;
  logic        clk = 1'b0;
  logic        reset, redirect_valid, out_ready, out_valid, fetch_fault;
  logic [31:0] imem_pc, imem_instr, redirect_pc, out_instr, out_pc;
  logic [31:0] rom [32];
  int passed = 0, total = 0;
  logic [63:0] q [$];
  logic [31:0] fpc;
  logic        flt, bad, pp, pu, found;

  ifetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;
  assign imem_instr = rom[imem_pc[6:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  // model: a queue of pending {pc, instr}, a fetch pointer and a sticky fault flag
  initial begin
    fpc = 32'h0;
    flt = 1'b0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        q.delete();
        fpc = 32'h0;
        flt = 1'b0;
      end else if (redirect_valid) begin
        q.delete();
        fpc = redirect_pc;
        flt = 1'b0;
      end else begin
        bad = fpc[1:0] != 2'b00 || fpc >= 32'd128;
        pp  = q.size() > 0 && out_ready;
        pu  = !flt && !bad && (q.size() < 2 || pp);
        if (pp) void'(q.pop_front());
        if (pu) begin
          q.push_back({fpc, rom[fpc[6:2]]});
          fpc = fpc + 32'd4;
        end
        if (bad) flt = 1'b1;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (!reset) begin
      chk("m_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
      if (q.size() > 0) begin
        chk("m_pc", out_pc, q[0][63:32]);
        chk("m_instr", out_instr, q[0][31:0]);
      end
      chk("m_imem_pc", imem_pc, fpc);
      chk("m_fault", {31'b0, fetch_fault}, {31'b0, flt});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'h0000_0013 | (i << 20);
    reset = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    found = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // 1: reset state, then 0,4,8,12 back to back
    chk("t1_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("t1_rst_pc", out_pc, 32'h0);
    chk("t1_rst_instr", out_instr, 32'h0);
    chk("t1_rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("t1_rst_imem_pc", imem_pc, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_valid", {31'b0, out_valid}, 32'd1);
      chk("t1_pc", out_pc, 32'(k * 4));
    end
    // 2: stalled decode fills the FIFO, fetch stalls at 8, drains in order
    reset = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("t2_imem_pc", imem_pc, 32'h8);
    chk("t2_pc0", out_pc, 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_pc4", out_pc, 32'h4);
    @(negedge clk);
    chk("t2_pc8", out_pc, 32'h8);
    // 3: redirect to 0x10 while full
    out_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t3_flush", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("t3_valid", {31'b0, out_valid}, 32'd1);
    chk("t3_pc", out_pc, 32'h10);
    chk("t3_instr", out_instr, 32'h0040_0013);
    // 4: run off the end of the ROM, then recover by redirecting to 0
    out_ready = 1'b1;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      found = out_valid && out_pc == 32'h7c;
    end
    chk("t4_reach_7c", {31'b0, found}, 32'd1);
    @(negedge clk);
    chk("t4_fault", {31'b0, fetch_fault}, 32'd1);
    chk("t4_imem_pc", imem_pc, 32'h80);
    chk("t4_valid", {31'b0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    chk("t4_no_push", {31'b0, out_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t4_clear", {31'b0, fetch_fault}, 32'd0);
    @(negedge clk);
    chk("t4_resume_valid", {31'b0, out_valid}, 32'd1);
    chk("t4_resume_pc", out_pc, 32'h0);
    // 5: misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc = 32'h6;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t5_imem_pc", imem_pc, 32'h6);
    @(negedge clk);
    chk("t5_fault", {31'b0, fetch_fault}, 32'd1);
    chk("t5_valid", {31'b0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    chk("t5_valid_hold", {31'b0, out_valid}, 32'd0);
    // 6: asynchronous reset with two entries queued
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    out_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_pre_valid", {31'b0, out_valid}, 32'd1);
    chk("t6_pre_imem_pc", imem_pc, 32'h8);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_async_pc", imem_pc, 32'h0);
    chk("t6_async_out_pc", out_pc, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_restart_valid", {31'b0, out_valid}, 32'd1);
    chk("t6_restart_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
